// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pong input path: debounce FSM encoding,
// button bit positions and the system clock rate.
package pong_pkg;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    PEND_P = 2'd1,
    PRESS  = 2'd2,
    PEND_R = 2'd3
  } btn_state_t;

  localparam int BTN_UP_P1   = 0;
  localparam int BTN_DOWN_P1 = 1;
  localparam int BTN_UP_P2   = 2;
  localparam int BTN_DOWN_P2 = 3;

  localparam int CLK_HZ = 25_175_000;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the pad side (master) and the conditioner (slave).
interface button_conditioner_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] btn_n_in;
  logic [N_BTN-1:0] btn_n_out;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic             any_press;
  logic [N_BTN-1:0] stuck;

  modport master (
    output btn_n_in,
    input  btn_n_out, press_pulse, release_pulse, any_press, stuck
  );

  modport slave (
    input  btn_n_in,
    output btn_n_out, press_pulse, release_pulse, any_press, stuck
  );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button: 2-FF synchroniser, 4-state debounce FSM with registered outputs,
// and a stuck-press detector built only when STUCK_DETECT_EN is defined.
module debounce_channel
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 251_750,
  parameter int CNT_W           = 18
`ifdef STUCK_DETECT_EN
  ,
  parameter int STUCK_CYCLES    = 251_750_000,
  parameter int STUCK_W         = 28
`endif
) (
  input  logic clk_0,
  input  logic rst,
  input  logic btn_raw_n,
  output logic level_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_next,
  output logic stuck
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync_q1;
  logic       s;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_d;
  logic       release_next;
  logic       rel_commit;
  logic       stuck_set;
  logic       stuck_q;

  // Sync flops reset to the released level so a held button looks like a fresh edge.
  always_ff @(posedge clk_0 or negedge rst) begin
    // NOTE: non-blocking assignments so each flop samples pre-edge values and the chain really delays.
    if (!rst) begin
      sync_q1 <= 1'b1;
      s       <= 1'b1;
    end else begin
      sync_q1 <= btn_raw_n;
      s       <= sync_q1;
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q       <= REL;
      cnt_q         <= '0;
      level_n       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_n       <= level_d;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    level_d      = level_n;
    press_next   = 1'b0;
    release_next = 1'b0;
    rel_commit   = 1'b0;
    unique case (state_q)
      REL: begin
        if (!s) begin
          state_d = PEND_P;
          cnt_d   = '0;
        end
      end
      PEND_P: begin
        if (s) begin
          state_d = REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = PRESS;
          level_d    = 1'b0;
          press_next = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESS: begin
        if (s) begin
          state_d = PEND_R;
          cnt_d   = '0;
        end else if (stuck_set) begin
          level_d = 1'b1;
        end
      end
      PEND_R: begin
        if (!s) begin
          state_d = PRESS;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = REL;
          level_d      = 1'b1;
          rel_commit   = 1'b1;
          // A stuck button was already reported released; stay silent on the real release.
          release_next = !stuck_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

`ifdef STUCK_DETECT_EN
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

  logic [STUCK_W-1:0] stuck_cnt_q;

  assign stuck_set = (state_q == PRESS) && !s && (stuck_cnt_q == STUCK_LAST);

  // Saturates at the threshold so the flag cannot re-fire by wrapping.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      if (state_q != PRESS)
        stuck_cnt_q <= '0;
      else if (stuck_cnt_q != STUCK_LAST)
        stuck_cnt_q <= stuck_cnt_q + STUCK_W'(1);

      if (rel_commit)
        stuck_q <= 1'b0;
      else if (stuck_set)
        stuck_q <= 1'b1;
    end
  end
`else
  assign stuck_set = 1'b0;
  assign stuck_q   = 1'b0;
`endif

  assign stuck = stuck_q;

endmodule

// File: rtl/button_conditioner.sv
// Four-channel button conditioner: per-channel debounce plus a registered
// any-press pulse. Define STUCK_DETECT_EN to build the stuck-button detectors.
module button_conditioner
  import pong_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 251_750,
  parameter int CNT_W           = 18,
  parameter int STUCK_CYCLES    = 251_750_000,
  parameter int STUCK_W         = 28
) (
  input logic                 clk_0,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((64'd1 << STUCK_W) <= 64'(STUCK_CYCLES)) begin : g_bad_stuck_w
    $error("STUCK_W too narrow for STUCK_CYCLES");
  end

  logic [N_BTN-1:0] level_n;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] press_next;
  logic [N_BTN-1:0] stuck;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef STUCK_DETECT_EN
      ,
      .STUCK_CYCLES   (STUCK_CYCLES),
      .STUCK_W        (STUCK_W)
`endif
    ) u_ch (
      .clk_0        (clk_0),
      .rst          (rst),
      .btn_raw_n    (bus.btn_n_in[i]),
      .level_n      (level_n[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .press_next   (press_next[i]),
      .stuck        (stuck[i])
    );
  end

  // Registered from the channels' next-cycle press terms so it lines up with press_pulse.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) any_press_q <= 1'b0;
    else      any_press_q <= |press_next;
  end

  assign bus.btn_n_out     = level_n;
  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.any_press     = any_press_q;
  assign bus.stuck         = stuck;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=8, STUCK_CYCLES=40.
module tb_button_conditioner;
  import pong_pkg::*;

  localparam int LAT = 11;  // 2 sync + 8 debounce + 1 output register
  localparam int STK = 40;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
    logic [3:0] out;
    logic [3:0] stk;
  } ev_t;

  logic clk_0 = 1'b0;
  logic rst   = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];
  logic [3:0] prev_out   = 4'hF;
  logic [3:0] prev_stuck = 4'h0;

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .STUCK_CYCLES   (STK),
    .STUCK_W        (6)
  ) dut (
    .clk_0(clk_0),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk_0 = ~clk_0;
  always @(posedge clk_0) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_0);
    #1;
  endtask

  task automatic push_ev(input int at, input logic [3:0] press, input logic [3:0] rel,
                         input logic [3:0] out, input logic [3:0] stk);
    ev_t e;
    e.cyc = at; e.press = press; e.rel = rel; e.any = |press; e.out = out; e.stk = stk;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse or level/flag change is an output event matched against the queue.
  always @(negedge clk_0) begin
    if (!rst) begin
      prev_out   = bus.btn_n_out;
      prev_stuck = bus.stuck;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.press_pulse != 4'h0 || bus.release_pulse != 4'h0 || bus.any_press ||
          bus.btn_n_out != prev_out || bus.stuck != prev_stuck) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output cyc=%0d press=%b release=%b any=%b out=%b stuck=%b required=none",
                   cyc, bus.press_pulse, bus.release_pulse, bus.any_press, bus.btn_n_out, bus.stuck);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("press_pulse", bus.press_pulse, e.press);
          check("release_pulse", bus.release_pulse, e.rel);
          check("any_press", bus.any_press, e.any);
          check("btn_n_out", bus.btn_n_out, e.out);
          check("stuck", bus.stuck, e.stk);
        end
      end
      prev_out   = bus.btn_n_out;
      prev_stuck = bus.stuck;
    end
  end

  initial begin
    int w;
    // Reset with every button held down.
    bus.btn_n_in = 4'h0;
    tick(3);
    check("rst_btn_n_out", bus.btn_n_out, 4'hF);
    check("rst_press", bus.press_pulse, 4'h0);
    check("rst_release", bus.release_pulse, 4'h0);
    check("rst_any", bus.any_press, 1'b0);
    check("rst_stuck", bus.stuck, 4'h0);

    // Held through reset release: fresh press on all four channels.
    rst = 1'b1;
    push_ev(cyc + LAT, 4'hF, 4'h0, 4'h0, 4'h0);
    tick(15);
    bus.btn_n_in = 4'hF;
    push_ev(cyc + LAT, 4'h0, 4'hF, 4'hF, 4'h0);
    tick(15);

    // Clean press and release on up_p1.
    bus.btn_n_in[BTN_UP_P1] = 1'b0;
    push_ev(cyc + LAT, 4'b0001, 4'h0, 4'b1110, 4'h0);
    tick(20);
    bus.btn_n_in[BTN_UP_P1] = 1'b1;
    push_ev(cyc + LAT, 4'h0, 4'b0001, 4'hF, 4'h0);
    tick(20);

    // Bounce on up_p2: 5 low, 1 high, then steady low.
    bus.btn_n_in[BTN_UP_P2] = 1'b0;
    tick(5);
    bus.btn_n_in[BTN_UP_P2] = 1'b1;
    tick(1);
    bus.btn_n_in[BTN_UP_P2] = 1'b0;
    push_ev(cyc + LAT, 4'b0100, 4'h0, 4'b1011, 4'h0);
    tick(20);
    bus.btn_n_in[BTN_UP_P2] = 1'b1;
    push_ev(cyc + LAT, 4'h0, 4'b0100, 4'hF, 4'h0);
    tick(20);

    // Glitch one cycle shorter than the debounce window: no output at all.
    bus.btn_n_in[BTN_DOWN_P1] = 1'b0;
    tick(7);
    bus.btn_n_in[BTN_DOWN_P1] = 1'b1;
    tick(20);

    // Simultaneous press of down_p1 and down_p2.
    bus.btn_n_in = 4'b0101;
    push_ev(cyc + LAT, 4'b1010, 4'h0, 4'b0101, 4'h0);
    tick(20);
    bus.btn_n_in = 4'hF;
    push_ev(cyc + LAT, 4'h0, 4'b1010, 4'hF, 4'h0);
    tick(20);

    // Reset pulse while up_p1 is committed: immediate release, no pulse, then re-commit.
    bus.btn_n_in[BTN_UP_P1] = 1'b0;
    push_ev(cyc + LAT, 4'b0001, 4'h0, 4'b1110, 4'h0);
    tick(15);
    rst = 1'b0;
    #1;
    check("midrst_btn_n_out", bus.btn_n_out, 4'hF);
    check("midrst_release", bus.release_pulse, 4'h0);
    tick(1);
    rst = 1'b1;
    push_ev(cyc + LAT, 4'b0001, 4'h0, 4'b1110, 4'h0);
    tick(20);
    bus.btn_n_in[BTN_UP_P1] = 1'b1;
    push_ev(cyc + LAT, 4'h0, 4'b0001, 4'hF, 4'h0);
    tick(20);

`ifdef STUCK_DETECT_EN
    // down_p2 held 60 cycles: flagged at commit+40, cleared silently on release.
    bus.btn_n_in[BTN_DOWN_P2] = 1'b0;
    push_ev(cyc + LAT, 4'b1000, 4'h0, 4'b0111, 4'h0);
    push_ev(cyc + LAT + STK, 4'h0, 4'h0, 4'hF, 4'b1000);
    tick(60);
    bus.btn_n_in[BTN_DOWN_P2] = 1'b1;
    push_ev(cyc + LAT, 4'h0, 4'h0, 4'hF, 4'h0);
    tick(20);
`endif

    // Drain with a bounded wait.
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick(1);
      w++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
